// File: rtl/mem_io_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_bridge_if
// Brief    : CPU load/store request bus, data-BRAM port and board I/O pins.
// Revision : 1.0
// ============================================================================
interface mem_io_bridge_if #(
    parameter int IO_W    = 16,
    parameter int NUM_OUT = 2,
    parameter int NUM_IN  = 2
);
    logic                      mem_read;
    logic                      mem_write;
    logic [1:0]                size;
    logic                      load_unsigned;
    logic [31:0]               addr_in;
    logic [31:0]               reg_wdata;
    logic [31:0]               mem_addr;
    logic [3:0]                mem_we;
    logic [31:0]               mem_wdata;
    logic [31:0]               mem_rdata;
    logic [NUM_IN*IO_W-1:0]    io_in;
    logic [NUM_OUT*IO_W-1:0]   io_out;
    logic [31:0]               rdata;
    logic                      rdata_valid;
    logic                      bus_err;

    modport master (
        output mem_read, mem_write, size, load_unsigned, addr_in, reg_wdata,
               mem_rdata, io_in,
        input  mem_addr, mem_we, mem_wdata, io_out, rdata, rdata_valid, bus_err
    );

    modport slave (
        input  mem_read, mem_write, size, load_unsigned, addr_in, reg_wdata,
               mem_rdata, io_in,
        output mem_addr, mem_we, mem_wdata, io_out, rdata, rdata_valid, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_bridge
// Brief    : Load/store decode to data BRAM or memory-mapped I/O channels.
// Revision : 1.0
// ============================================================================
module mem_io_bridge #(
    parameter logic [31:0] IO_BASE     = 32'hFFFF_FC00,
    parameter int          IO_W        = 16,
    parameter int          NUM_OUT     = 2,
    parameter int          NUM_IN      = 2,
    parameter int          SYNC_STAGES = 2
) (
    input wire             clk,
    input wire             rst_n,
    mem_io_bridge_if.slave bus
);
    localparam int IN_BITS  = NUM_IN * IO_W;
    localparam int OUT_BITS = NUM_OUT * IO_W;

    logic                is_io;
    logic [9:0]          offset;
    logic [NUM_OUT-1:0]  sel_out;
    logic [NUM_IN-1:0]   sel_in;
    logic                sel_status;
    logic                io_bad;
    logic                mem_bad;
    logic                err;
    logic                wr_ok;
    logic                rd_ok;
    logic [3:0]          lanes;
    logic [31:0]         io_val;
    logic [15:0]         lane_data;
    logic [NUM_IN-1:0]   change;

    logic [IN_BITS-1:0]  sync_d [SYNC_STAGES];
    logic [IN_BITS-1:0]  sync_q [SYNC_STAGES];
    logic [IN_BITS-1:0]  prev_d, prev_q;
    logic [NUM_IN-1:0]   status_d, status_q;
    logic [OUT_BITS-1:0] io_out_d, io_out_q;
    logic                rdata_valid_d, rdata_valid_q;
    logic                bus_err_d, bus_err_q;
    logic                ld_mem_d, ld_mem_q;
    logic                ld_uns_d, ld_uns_q;
    logic [1:0]          ld_lane_d, ld_lane_q;
    logic [1:0]          ld_size_d, ld_size_q;
    logic [31:0]         io_rdata_d, io_rdata_q;

    // Address decode and access legality
    always_comb begin
        is_io   = (bus.addr_in[31:10] == IO_BASE[31:10]);
        offset  = bus.addr_in[9:0];
        sel_out = '0;
        sel_in  = '0;
        for (int k = 0; k < NUM_OUT; k++) sel_out[k] = (offset == 10'(4 * k));
        for (int j = 0; j < NUM_IN; j++)  sel_in[j]  = (offset == 10'(64 + 4 * j));
        sel_status = (offset == 10'h080);

        if (|sel_out)                      io_bad = 1'b0;
        else if ((|sel_in) || sel_status)  io_bad = bus.mem_write;
        else                               io_bad = 1'b1;

        // Size only matters on the memory side; the I/O window is word-only.
        mem_bad = (bus.size == 2'b11)
                | ((bus.size == 2'b01) & bus.addr_in[0])
                | ((bus.size == 2'b10) & (|bus.addr_in[1:0]));

        err   = (bus.mem_read | bus.mem_write)
              & ((bus.mem_read & bus.mem_write) | (is_io ? io_bad : mem_bad));
        wr_ok = bus.mem_write & ~err;
        rd_ok = bus.mem_read & ~err;
    end

    // Store lanes towards the BRAM
    always_comb begin
        case (bus.size)
            2'b00: begin
                lanes         = 4'b0001 << bus.addr_in[1:0];
                bus.mem_wdata = {4{bus.reg_wdata[7:0]}};
            end
            2'b01: begin
                lanes         = 4'b0011 << {bus.addr_in[1], 1'b0};
                bus.mem_wdata = {2{bus.reg_wdata[15:0]}};
            end
            default: begin
                lanes         = 4'b1111;
                bus.mem_wdata = bus.reg_wdata;
            end
        endcase
        bus.mem_we   = (wr_ok && !is_io) ? lanes : 4'b0000;
        bus.mem_addr = {bus.addr_in[31:2], 2'b00};
    end

    // I/O registers, input synchronisers and change status
    always_comb begin
        io_out_d = io_out_q;
        io_val   = '0;
        change   = '0;
        sync_d   = sync_q;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (wr_ok && is_io && sel_out[k]) io_out_d[k*IO_W +: IO_W] = bus.reg_wdata[IO_W-1:0];
            if (sel_out[k]) io_val[IO_W-1:0] = io_out_q[k*IO_W +: IO_W];
        end
        for (int j = 0; j < NUM_IN; j++) begin
            if (sel_in[j]) io_val[IO_W-1:0] = sync_q[SYNC_STAGES-1][j*IO_W +: IO_W];
            change[j] = |(sync_q[SYNC_STAGES-1][j*IO_W +: IO_W] ^ prev_q[j*IO_W +: IO_W]);
        end
        if (sel_status) io_val[NUM_IN-1:0] = status_q;
        // An edge landing in the clearing cycle must survive the clear.
        status_d  = (status_q & ~{NUM_IN{rd_ok && is_io && sel_status}}) | change;
        prev_d    = sync_q[SYNC_STAGES-1];
        sync_d[0] = bus.io_in;
        for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    end

    // Load pipeline control
    always_comb begin
        rdata_valid_d = bus.mem_read;
        bus_err_d     = err;
        ld_mem_d      = rd_ok & ~is_io;
        ld_lane_d     = bus.addr_in[1:0];
        ld_size_d     = bus.size;
        ld_uns_d      = bus.load_unsigned;
        io_rdata_d    = (rd_ok && is_io) ? io_val : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '{default: '0};
            prev_q        <= '0;
            status_q      <= '0;
            io_out_q      <= '0;
            rdata_valid_q <= 1'b0;
            bus_err_q     <= 1'b0;
            ld_mem_q      <= 1'b0;
            ld_uns_q      <= 1'b0;
            ld_lane_q     <= 2'b00;
            ld_size_q     <= 2'b00;
            io_rdata_q    <= 32'h0;
        end else begin
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            status_q      <= status_d;
            io_out_q      <= io_out_d;
            rdata_valid_q <= rdata_valid_d;
            bus_err_q     <= bus_err_d;
            ld_mem_q      <= ld_mem_d;
            ld_uns_q      <= ld_uns_d;
            ld_lane_q     <= ld_lane_d;
            ld_size_q     <= ld_size_d;
            io_rdata_q    <= io_rdata_d;
        end
    end

    // Memory loads extend straight from the BRAM output using the latched lane/size.
    always_comb begin
        lane_data = 16'(bus.mem_rdata >> {ld_lane_q, 3'b000});
        bus.rdata = 32'h0;
        if (rdata_valid_q && ld_mem_q) begin
            case (ld_size_q)
                2'b00:   bus.rdata = ld_uns_q ? {24'h0, lane_data[7:0]}
                                              : {{24{lane_data[7]}}, lane_data[7:0]};
                2'b01:   bus.rdata = ld_uns_q ? {16'h0, lane_data}
                                              : {{16{lane_data[15]}}, lane_data};
                default: bus.rdata = bus.mem_rdata;
            endcase
        end else if (rdata_valid_q) begin
            bus.rdata = io_rdata_q;
        end
    end

    assign bus.io_out      = io_out_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.bus_err     = bus_err_q;
endmodule
`default_nettype wire
